button_intr_ctrl: RTL and testbench

- Front-end interrupt source for the CPU; sits directly upstream of the dataloger top's `intr` vector.
- Takes the four raw, asynchronous, active-low push buttons and synchronises and debounces each one.
- Converts each debounced press into a sticky pending-interrupt bit on `intr`. A bit stays set until the CPU acknowledges it.
- Replaces the combinational button decode, so there is no lost, chattering or unlatched request.

---
 rtl/button_intr_ctrl_pkg.sv | 23 ++
 rtl/button_debounce.sv | 80 ++++++++
 rtl/button_intr_ctrl.sv | 69 ++++++
 tb/tb_button_intr_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/button_intr_ctrl_pkg.sv
// Shared constants and types for the button interrupt front end.
// Bit map of debounced buttons onto the CPU interrupt vector.
package button_intr_ctrl_pkg;

    localparam int unsigned INTR_W = 8;
    localparam int unsigned N_BTN  = 4;

    // 5 ms at 50 MHz
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;

    localparam int unsigned BTN0_INTR = 0;
    localparam int unsigned BTN1_INTR = 1;
    localparam int unsigned BTN2_INTR = 2;
    localparam int unsigned BTN3_INTR = 3;

    localparam int unsigned BTN_INTR_IDX [N_BTN] = '{BTN0_INTR, BTN1_INTR, BTN2_INTR, BTN3_INTR};

    typedef enum logic {
        StStable,
        StCounting
    } db_state_e;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counting debouncer for one active-low button.
// level is the debounced pressed state; press pulses on the accepting edge of a press.
module button_debounce
    import button_intr_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    db_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            stable_q, stable_d;
    logic            differ;
    logic            flip;

    // stable_q is kept active-high, so compare against the inverted raw level
    assign differ = (~sync_q[1]) != stable_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= 2'b11;
            state_q  <= StStable;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_n};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        flip     = 1'b0;
        unique case (state_q)
            StStable: begin
                cnt_d = '0;
                if (differ) begin
                    state_d = StCounting;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            StCounting: begin
                if (!differ) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d  = StStable;
                    cnt_d    = '0;
                    stable_d = ~stable_q;
                    flip     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StStable;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        level = stable_q;
        press = flip && !stable_q;
    end

endmodule

// File: rtl/button_intr_ctrl.sv
// Debounced push buttons to sticky, CPU-acknowledged interrupt bits.
// Define INTR_MASK_EN to add the intr_mask port and gate intr/irq_any with it.
module button_intr_ctrl
    import button_intr_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BTN-1:0]  buttons,
    input  logic [INTR_W-1:0] intr_ack,
`ifdef INTR_MASK_EN
    input  logic [INTR_W-1:0] intr_mask,
`endif
    output logic [INTR_W-1:0] intr,
    output logic [N_BTN-1:0]  btn_level,
    output logic              irq_any
);

    logic [N_BTN-1:0]  press;
    logic [N_BTN-1:0]  pending_q, pending_d;
    logic [INTR_W-1:0] intr_q, intr_d;
    logic              irq_q, irq_d;
    logic              unused_ack;

    assign unused_ack = ^intr_ack[INTR_W-1:N_BTN];

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .btn_n(buttons[i]),
            .level(btn_level[i]),
            .press(press[i])
        );
    end

    always_comb begin
        pending_d = '0;
        intr_d    = '0;
        for (int i = 0; i < N_BTN; i++) begin
            // set after clear: a press coinciding with an ack is kept
            pending_d[i] = (pending_q[i] & ~intr_ack[BTN_INTR_IDX[i]]) | press[i];
            intr_d[BTN_INTR_IDX[i]] = pending_d[i];
        end
`ifdef INTR_MASK_EN
        intr_d = intr_d & intr_mask;
`endif
        irq_d = |intr_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            intr_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            intr_q    <= intr_d;
            irq_q     <= irq_d;
        end
    end

    assign intr    = intr_q;
    assign irq_any = irq_q;

endmodule

// File: tb/tb_button_intr_ctrl.sv
// Directed bench for button_intr_ctrl with DEBOUNCE_CYCLES = 4 (6-edge press latency).
// Mask checks are compiled in only when INTR_MASK_EN is defined.
module tb_button_intr_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] buttons;
    logic [7:0] intr_ack;
`ifdef INTR_MASK_EN
    logic [7:0] intr_mask;
`endif
    logic [7:0] intr;
    logic [3:0] btn_level;
    logic       irq_any;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_intr_ctrl #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .buttons  (buttons),
        .intr_ack (intr_ack),
`ifdef INTR_MASK_EN
        .intr_mask(intr_mask),
`endif
        .intr     (intr),
        .btn_level(btn_level),
        .irq_any  (irq_any)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        buttons  = 4'b1111;
        intr_ack = 8'h00;
`ifdef INTR_MASK_EN
        intr_mask = 8'hFF;
`endif
        tick(3);
        check("rst_intr", 32'(intr), 32'h00);
        check("rst_level", 32'(btn_level), 32'h0);
        check("rst_irq", 32'(irq_any), 32'h0);
        reset = 1'b0;
        tick(1);

        // Single press: 6 edges to accept
        buttons = 4'b1110;
        tick(5);
        check("b0_early_intr", 32'(intr), 32'h00);
        check("b0_early_level", 32'(btn_level), 32'h0);
        tick(1);
        check("b0_intr", 32'(intr), 32'h01);
        check("b0_level", 32'(btn_level), 32'h1);
        check("b0_irq", 32'(irq_any), 32'h1);
        buttons = 4'b1111;
        tick(8);
        check("b0_rel_intr", 32'(intr), 32'h01);
        check("b0_rel_level", 32'(btn_level), 32'h0);

        intr_ack = 8'h01;
        tick(1);
        intr_ack = 8'h00;
        check("ack_intr", 32'(intr), 32'h00);
        check("ack_irq", 32'(irq_any), 32'h0);

        // Bounce on button 2: low 3, high 1, twice
        for (int r = 0; r < 2; r++) begin
            buttons = 4'b1011;
            tick(3);
            buttons = 4'b1111;
            tick(1);
        end
        tick(8);
        check("glitch_intr", 32'(intr), 32'h00);
        check("glitch_level", 32'(btn_level), 32'h0);

        // Ack coinciding with a fresh press event on an already-pending bit
        buttons = 4'b1110;
        tick(6);
        check("p1_intr", 32'(intr), 32'h01);
        buttons = 4'b1111;
        tick(8);
        buttons = 4'b1110;
        tick(5);
        intr_ack = 8'h01;
        tick(1);
        intr_ack = 8'h00;
        check("ack_vs_press_intr", 32'(intr), 32'h01);
        check("ack_vs_press_irq", 32'(irq_any), 32'h1);
        intr_ack = 8'h01;
        tick(1);
        intr_ack = 8'h00;
        check("ack2_intr", 32'(intr), 32'h00);
        buttons = 4'b1111;
        tick(8);

        // Buttons 0 and 3 together
        buttons = 4'b0110;
        tick(5);
        check("dual_early", 32'(intr), 32'h00);
        tick(1);
        check("dual_intr", 32'(intr), 32'h09);
        check("dual_level", 32'(btn_level), 32'h9);
        check("dual_irq", 32'(irq_any), 32'h1);
        intr_ack = 8'hF0;
        tick(1);
        intr_ack = 8'h00;
        check("ack_hi_intr", 32'(intr), 32'h09);
        intr_ack = 8'h09;
        tick(1);
        intr_ack = 8'h00;
        check("ack_dual_intr", 32'(intr), 32'h00);
        buttons = 4'b1111;
        tick(8);

        // Reset mid-count, button 1 stays held and is re-qualified from zero
        buttons = 4'b1101;
        tick(4);
        reset = 1'b1;
        tick(1);
        check("midrst_intr", 32'(intr), 32'h00);
        check("midrst_level", 32'(btn_level), 32'h0);
        reset = 1'b0;
        tick(5);
        check("requal_early", 32'(intr), 32'h00);
        tick(1);
        check("requal_intr", 32'(intr), 32'h02);
        check("requal_level", 32'(btn_level), 32'h2);
        buttons = 4'b1111;
        intr_ack = 8'h02;
        tick(1);
        intr_ack = 8'h00;
        check("requal_ack", 32'(intr), 32'h00);
        tick(8);

`ifdef INTR_MASK_EN
        intr_mask = 8'h00;
        buttons = 4'b1101;
        tick(6);
        check("masked_intr", 32'(intr), 32'h00);
        check("masked_irq", 32'(irq_any), 32'h0);
        check("masked_level", 32'(btn_level), 32'h2);
        intr_mask = 8'h02;
        tick(1);
        check("unmask_intr", 32'(intr), 32'h02);
        check("unmask_irq", 32'(irq_any), 32'h1);
        buttons = 4'b1111;
        tick(8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
